// File: rtl/decode_queue.sv
// decode_queue: circular instruction queue between fetch and decode.
//   Fetch pushes one or two instrs per cycle (slot 0 older). Decode sees the
//   head and head+1 entries; the second one is offered only when it can issue
//   alongside the first (no RAW on slot-0 dest, no exceptions, no control
//   transfer in slot 1, no SYSCALL/BREAK in slot 0).
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   flush                drop all queued instrs, pointers back to 0
//   in_valid, in_two     fetch offer and its size (1 or 2 instrs)
//   in_pc/instr/exc[2]   per-slot fetch payload
//   in_ready             at least two free entries and no flush
//   out_valid[2]         presentable head / head+1 entries
//   out_pc/instr/exc[2]  head / head+1 entry contents
//   out_ready            decode consumes every valid output slot
//   count                current occupancy
module decode_queue #(
   parameter int DEPTH      = 8,
   parameter bit DUAL_ISSUE = 1'b1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         in_valid,
   input  logic                         in_two,
   input  logic [1:0][31:0]             in_pc,
   input  logic [1:0][31:0]             in_instr,
   input  logic [1:0]                   in_exc,
   output logic                         in_ready,
   output logic [1:0]                   out_valid,
   output logic [1:0][31:0]             out_pc,
   output logic [1:0][31:0]             out_instr,
   output logic [1:0]                   out_exc,
   input  logic                         out_ready,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [31:0] pc_mem    [DEPTH];
   logic [31:0] instr_mem [DEPTH];
   logic        exc_mem   [DEPTH];

   logic [PW-1:0] head, tail, head1, tail1;
   logic          enq, pair_block;
   logic [CW-1:0] enq_n, deq_n;

   // Destination register written by an instr (0 = none).
   function automatic logic [4:0] dest_of(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd);
      logic [4:0] d;
      d = 5'd0;
      if (op == 6'h00)                              d = rd;
      else if (op == 6'h03)                         d = 5'd31;
      else if (op == 6'h01)                         d = rt[4] ? 5'd31 : 5'd0;
      else if (op[5:3] == 3'b001 || op[5:3] == 3'b100) d = rt;
      else if (op == 6'h10 && rs == 5'd0)           d = rt;
      return d;
   endfunction

   // Branches and jumps must lead their own issue group.
   function automatic logic is_cti(input logic [5:0] op, input logic [5:0] fn);
      return (op == 6'h01) || (op >= 6'h02 && op <= 6'h07) ||
             (op == 6'h00 && (fn == 6'h08 || fn == 6'h09));
   endfunction

   assign head1 = head + 1'b1;
   assign tail1 = tail + 1'b1;

   always_comb begin
      out_pc[0]    = pc_mem[head];
      out_instr[0] = instr_mem[head];
      out_exc[0]   = exc_mem[head];
      out_pc[1]    = pc_mem[head1];
      out_instr[1] = instr_mem[head1];
      out_exc[1]   = exc_mem[head1];
   end

   logic [4:0] d0;
   logic [5:0] op0, op1, fn0, fn1;
   logic [4:0] rs1, rt1;

   always_comb begin
      op0 = out_instr[0][31:26];
      fn0 = out_instr[0][5:0];
      op1 = out_instr[1][31:26];
      fn1 = out_instr[1][5:0];
      rs1 = out_instr[1][25:21];
      rt1 = out_instr[1][20:16];
      d0  = dest_of(op0, out_instr[0][25:21], out_instr[0][20:16], out_instr[0][15:11]);
      pair_block = ((d0 != 5'd0) && (d0 == rs1 || d0 == rt1)) ||
                   out_exc[0] || out_exc[1] ||
                   is_cti(op1, fn1) ||
                   (op0 == 6'h00 && (fn0 == 6'h0C || fn0 == 6'h0D));
   end

   assign out_valid[0] = (count != '0);
   assign out_valid[1] = DUAL_ISSUE && (count >= CW'(2)) && !pair_block;

   // Offers are all-or-nothing, so a free pair is required even for one instr.
   assign in_ready = !flush && (count <= CW'(DEPTH-2));
   assign enq      = in_valid && in_ready;
   assign enq_n    = enq ? (in_two ? CW'(2) : CW'(1)) : '0;
   assign deq_n    = out_ready ? (CW'(out_valid[0]) + CW'(out_valid[1])) : '0;

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + deq_n[PW-1:0];
         tail  <= tail + enq_n[PW-1:0];
         count <= count + enq_n - deq_n;
      end
   end

   // Storage is not reset; occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (enq && !reset) begin
         pc_mem[tail]    <= in_pc[0];
         instr_mem[tail] <= in_instr[0];
         exc_mem[tail]   <= in_exc[0];
         if (in_two) begin
            pc_mem[tail1]    <= in_pc[1];
            instr_mem[tail1] <= in_instr[1];
            exc_mem[tail1]   <= in_exc[1];
         end
      end
   end

endmodule

// File: tb/tb_decode_queue.sv
module tb_decode_queue;
   localparam int DEPTH = 8;
   localparam logic [31:0] ADDU = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21};
   localparam logic [31:0] ORI6 = {6'h00, 5'd4, 5'd6, 5'd5, 5'd0, 6'h25};
   localparam logic [31:0] SUBU = {6'h00, 5'd3, 5'd4, 5'd7, 5'd0, 6'h23};
   localparam logic [31:0] BEQ  = {6'h04, 5'd1, 5'd2, 16'h0010};
   localparam logic [31:0] NOP  = 32'h0;

   typedef struct packed { logic [31:0] pc; logic [31:0] instr; logic exc; } ent_t;

   logic clk = 1'b0;
   logic reset, flush, in_valid, in_two, out_ready;
   logic [1:0][31:0] in_pc, in_instr;
   logic [1:0] in_exc;
   logic [1:0] ir;
   logic [1:0][1:0] ov, oexc;
   logic [1:0][1:0][31:0] opc, oins;
   logic [1:0][3:0] cnt;

   int nvec = 0, nerr = 0;
   ent_t q0[$], q1[$];

   always #5 clk = ~clk;

   decode_queue #(.DEPTH(DEPTH), .DUAL_ISSUE(1'b1)) u_dual (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_two(in_two),
      .in_pc(in_pc), .in_instr(in_instr), .in_exc(in_exc), .in_ready(ir[0]),
      .out_valid(ov[0]), .out_pc(opc[0]), .out_instr(oins[0]), .out_exc(oexc[0]),
      .out_ready(out_ready), .count(cnt[0]));

   decode_queue #(.DEPTH(DEPTH), .DUAL_ISSUE(1'b0)) u_single (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_two(in_two),
      .in_pc(in_pc), .in_instr(in_instr), .in_exc(in_exc), .in_ready(ir[1]),
      .out_valid(ov[1]), .out_pc(opc[1]), .out_instr(oins[1]), .out_exc(oexc[1]),
      .out_ready(out_ready), .count(cnt[1]));

   // ---------------- reference model ----------------
   function automatic int qsz(input int d);
      return (d == 0) ? q0.size() : q1.size();
   endfunction

   function automatic ent_t qget(input int d, input int k);
      if (qsz(d) <= k) return '0;
      return (d == 0) ? q0[k] : q1[k];
   endfunction

   function automatic logic [4:0] m_dest(input logic [31:0] w);
      logic [5:0] op = w[31:26];
      if (op == 6'h00) return w[15:11];
      if (op == 6'h03) return 5'd31;
      if (op == 6'h01) return w[20] ? 5'd31 : 5'd0;
      if ((op >= 6'h08 && op <= 6'h0F) || (op >= 6'h20 && op <= 6'h27)) return w[20:16];
      if (op == 6'h10 && w[25:21] == 5'd0) return w[20:16];
      return 5'd0;
   endfunction

   function automatic bit m_block(input ent_t a, input ent_t b);
      logic [4:0] d = m_dest(a.instr);
      logic [5:0] ob = b.instr[31:26], fb = b.instr[5:0];
      logic [5:0] oa = a.instr[31:26], fa = a.instr[5:0];
      bit raw  = (d != 0) && (d == b.instr[25:21] || d == b.instr[20:16]);
      bit cti  = (ob >= 6'h01 && ob <= 6'h07) || (ob == 6'h00 && (fb == 6'h08 || fb == 6'h09));
      bit trap = (oa == 6'h00) && (fa == 6'h0C || fa == 6'h0D);
      return raw || a.exc || b.exc || cti || trap;
   endfunction

   function automatic logic [1:0] m_ov(input int d);
      int n = qsz(d);
      logic v1 = (d == 0) && (n >= 2) && !m_block(qget(d, 0), qget(d, 1));
      return {v1, logic'(n >= 1)};
   endfunction

   function automatic logic m_ir(input int d);
      return !flush && (DEPTH - qsz(d) >= 2);
   endfunction

   task automatic model_edge();
      for (int d = 0; d < 2; d++) begin
         logic [1:0] v = m_ov(d);
         int ndeq = out_ready ? (int'(v[0]) + int'(v[1])) : 0;
         bit enq = in_valid && m_ir(d);
         ent_t e0 = '{pc: in_pc[0], instr: in_instr[0], exc: in_exc[0]};
         ent_t e1 = '{pc: in_pc[1], instr: in_instr[1], exc: in_exc[1]};
         if (reset || flush) begin
            if (d == 0) q0.delete(); else q1.delete();
         end else begin
            for (int k = 0; k < ndeq; k++) if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            if (enq) begin
               if (d == 0) q0.push_back(e0); else q1.push_back(e0);
               if (in_two) begin if (d == 0) q0.push_back(e1); else q1.push_back(e1); end
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle_inputs();
      flush = 0; in_valid = 0; in_two = 0; out_ready = 0;
      in_pc = '0; in_instr = '0; in_exc = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1; tick(); reset = 0;
   endtask

   task automatic offer(input logic two, input logic [31:0] pc0, input logic [31:0] i0,
                        input logic [31:0] i1);
      in_valid = 1; in_two = two;
      in_pc[0] = pc0; in_pc[1] = pc0 + 4;
      in_instr[0] = i0; in_instr[1] = i1; in_exc = '0;
   endtask

   function automatic logic [31:0] rnd_instr();
      logic [4:0] a = 5'($urandom_range(0, 7));
      logic [4:0] b = 5'($urandom_range(0, 7));
      logic [4:0] c = 5'($urandom_range(0, 7));
      case ($urandom_range(0, 10))
         0: return {6'h00, a, b, c, 5'd0, 6'h21};
         1: return {6'h00, a, b, c, 5'd0, 6'h23};
         2: return {6'h04, a, b, 16'h0008};
         3: return {6'h02, 26'h40};
         4: return {6'h00, a, 15'd0, 6'h08};
         5: return {26'd0, 6'h0C};
         6: return {6'h23, a, b, 16'h0004};
         7: return {6'h09, a, b, 16'h0001};
         8: return {6'h10, 5'd0, b, c, 11'd0};
         9: return {6'h01, a, 5'h11, 16'h0004};
         default: return $urandom;
      endcase
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      offer(1, 32'h100, ADDU, ORI6); tick();
      // reset wins over a concurrent enqueue and dequeue
      reset = 1; out_ready = 1; tick();
      idle_inputs(); reset = 0; #1;
      for (int d = 0; d < 2; d++) begin
         nvec++; if (cnt[d] !== 4'd0) begin nerr++; $display("FAIL reset_count[%0d]: got %0d want 0", d, cnt[d]); end
         nvec++; if (ov[d] !== 2'b00) begin nerr++; $display("FAIL reset_valid[%0d]: got %b want 00", d, ov[d]); end
         nvec++; if (ir[d] !== 1'b1) begin nerr++; $display("FAIL reset_ready[%0d]: got %b want 1", d, ir[d]); end
      end
   endtask

   task automatic test_pair();
      do_reset();
      offer(1, 32'hBFC00000, ADDU, ORI6); #1;
      nvec++; if (ov[0] !== 2'b00) begin nerr++; $display("FAIL no_bypass: got %b want 00", ov[0]); end
      tick(); idle_inputs(); #1;
      nvec++; if (cnt[0] !== 4'd2) begin nerr++; $display("FAIL pair_count: got %0d want 2", cnt[0]); end
      nvec++; if (ov[0] !== 2'b11) begin nerr++; $display("FAIL pair_valid: got %b want 11", ov[0]); end
      nvec++; if (opc[0] !== {32'hBFC00004, 32'hBFC00000}) begin nerr++; $display("FAIL pair_pc: got %h want bfc00004bfc00000", opc[0]); end
      nvec++; if (ov[1] !== 2'b01) begin nerr++; $display("FAIL single_issue_valid: got %b want 01", ov[1]); end
   endtask

   task automatic test_raw_hazard();
      do_reset();
      offer(1, 32'h200, ADDU, SUBU); tick(); idle_inputs(); #1;
      nvec++; if (ov[0] !== 2'b01) begin nerr++; $display("FAIL raw_valid: got %b want 01", ov[0]); end
      out_ready = 1; tick(); out_ready = 0; #1;
      nvec++; if (oins[0][0] !== SUBU) begin nerr++; $display("FAIL raw_head: got %h want %h", oins[0][0], SUBU); end
      nvec++; if (cnt[0] !== 4'd1) begin nerr++; $display("FAIL raw_count: got %0d want 1", cnt[0]); end
   endtask

   task automatic test_branch();
      do_reset();
      offer(1, 32'h300, ADDU, BEQ); tick(); idle_inputs(); #1;
      nvec++; if (ov[0] !== 2'b01) begin nerr++; $display("FAIL br_slot1_valid: got %b want 01", ov[0]); end
      do_reset();
      offer(1, 32'h400, BEQ, NOP); tick(); idle_inputs(); #1;
      nvec++; if (ov[0] !== 2'b11) begin nerr++; $display("FAIL br_delay_valid: got %b want 11", ov[0]); end
   endtask

   task automatic test_full();
      do_reset();
      for (int k = 0; k < 4; k++) begin offer(1, 32'h500 + 8*k, ADDU, ORI6); tick(); end
      #1;
      nvec++; if (cnt[0] !== 4'd8) begin nerr++; $display("FAIL full_count: got %0d want 8", cnt[0]); end
      nvec++; if (ir[0] !== 1'b0) begin nerr++; $display("FAIL full_ready: got %b want 0", ir[0]); end
      out_ready = 1; tick(); #1;
      nvec++; if (ir[0] !== 1'b1) begin nerr++; $display("FAIL drain_ready: got %b want 1", ir[0]); end
      nvec++; if (cnt[0] !== 4'd6) begin nerr++; $display("FAIL drain_count: got %0d want 6", cnt[0]); end
      tick(); #1;
      nvec++; if (cnt[0] !== 4'd6) begin nerr++; $display("FAIL enq_deq_count: got %0d want 6", cnt[0]); end
      nvec++; if (opc[0][0] !== 32'h510) begin nerr++; $display("FAIL enq_deq_head: got %h want 00000510", opc[0][0]); end
      idle_inputs();
   endtask

   task automatic test_flush();
      do_reset();
      offer(1, 32'h600, ADDU, ORI6); tick();
      offer(1, 32'h608, ADDU, ORI6); tick();
      offer(0, 32'h610, ADDU, NOP);  tick();
      idle_inputs(); #1;
      nvec++; if (cnt[0] !== 4'd5) begin nerr++; $display("FAIL pre_flush_count: got %0d want 5", cnt[0]); end
      offer(1, 32'h620, ADDU, ORI6); flush = 1; out_ready = 1; #1;
      nvec++; if (ir[0] !== 1'b0) begin nerr++; $display("FAIL flush_ready: got %b want 0", ir[0]); end
      tick(); idle_inputs(); #1;
      nvec++; if (cnt[0] !== 4'd0) begin nerr++; $display("FAIL flush_count: got %0d want 0", cnt[0]); end
      nvec++; if (ov[0] !== 2'b00) begin nerr++; $display("FAIL flush_valid: got %b want 00", ov[0]); end
      nvec++; if (ir[0] !== 1'b1) begin nerr++; $display("FAIL post_flush_ready: got %b want 1", ir[0]); end
   endtask

   task automatic test_single_issue_wrap();
      int issued = 0, retired = 0;
      logic [31:0] exp_pc = 32'h1000;
      do_reset();
      out_ready = 1;
      for (int cyc = 0; cyc < 300 && retired < 3*DEPTH; cyc++) begin
         if (issued < 3*DEPTH && (DEPTH - qsz(1) >= 2)) begin
            offer(1, 32'h1000 + 4*issued, ADDU, ORI6); issued += 2;
         end else in_valid = 0;
         #1;
         nvec++;
         if (ov[1] !== (qsz(1) > 0 ? 2'b01 : 2'b00)) begin
            nerr++; $display("FAIL si_valid: got %b want %b", ov[1], (qsz(1) > 0 ? 2'b01 : 2'b00));
         end
         if (ov[1][0]) begin
            nvec++;
            if (opc[1][0] !== exp_pc) begin nerr++; $display("FAIL si_order: got %h want %h", opc[1][0], exp_pc); end
            exp_pc += 4; retired++;
         end
         tick();
      end
      nvec++; if (retired != 3*DEPTH) begin nerr++; $display("FAIL si_timeout: got %0d want %0d", retired, 3*DEPTH); end
      idle_inputs();
   endtask

   task automatic test_random();
      do_reset();
      for (int cyc = 0; cyc < 1500; cyc++) begin
         reset     = ($urandom_range(0, 199) == 0);
         flush     = ($urandom_range(0, 29) == 0);
         in_valid  = ($urandom_range(0, 3) != 0);
         in_two    = 1'($urandom_range(0, 1));
         in_pc[0]  = $urandom; in_pc[1] = $urandom;
         in_instr[0] = rnd_instr(); in_instr[1] = rnd_instr();
         in_exc[0] = ($urandom_range(0, 15) == 0);
         in_exc[1] = ($urandom_range(0, 15) == 0);
         out_ready = ($urandom_range(0, 2) != 0);
         #1;
         for (int d = 0; d < 2; d++) begin
            ent_t h0 = qget(d, 0), h1 = qget(d, 1);
            nvec++; if (ov[d] !== m_ov(d)) begin nerr++; $display("FAIL rnd_valid[%0d] cyc %0d: got %b want %b", d, cyc, ov[d], m_ov(d)); end
            nvec++; if (cnt[d] !== 4'(qsz(d))) begin nerr++; $display("FAIL rnd_count[%0d] cyc %0d: got %0d want %0d", d, cyc, cnt[d], qsz(d)); end
            nvec++; if (ir[d] !== m_ir(d)) begin nerr++; $display("FAIL rnd_ready[%0d] cyc %0d: got %b want %b", d, cyc, ir[d], m_ir(d)); end
            if (qsz(d) >= 1) begin
               nvec++;
               if ({opc[d][0], oins[d][0], oexc[d][0]} !== h0) begin
                  nerr++; $display("FAIL rnd_slot0[%0d] cyc %0d: got %h want %h", d, cyc, {opc[d][0], oins[d][0], oexc[d][0]}, h0);
               end
            end
            if (qsz(d) >= 2) begin
               nvec++;
               if ({opc[d][1], oins[d][1], oexc[d][1]} !== h1) begin
                  nerr++; $display("FAIL rnd_slot1[%0d] cyc %0d: got %h want %h", d, cyc, {opc[d][1], oins[d][1], oexc[d][1]}, h1);
               end
            end
         end
         tick();
      end
      reset = 0; idle_inputs();
   endtask

   initial begin
      reset = 1; idle_inputs();
      test_reset();
      test_pair();
      test_raw_hazard();
      test_branch();
      test_full();
      test_flush();
      test_single_issue_wrap();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
